// File: rtl/counter_preset_ctrl_pkg.sv
// Shared types for the counter_preset sequencer.
package counter_preset_ctrl_pkg;
   `include "counter_ctrl_defs.vh"

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_LOAD  = ST_LOAD,
      S_COUNT = ST_COUNT,
      S_DONE  = ST_DONE
   } state_e;
endpackage

// File: rtl/counter_ctrl_defs.vh
// State codes for the counter_preset_ctrl sequencer, shared by RTL and bench.
`ifndef COUNTER_CTRL_DEFS_VH
`define COUNTER_CTRL_DEFS_VH
localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_LOAD  = 2'd1;
localparam logic [1:0] ST_COUNT = 2'd2;
localparam logic [1:0] ST_DONE  = 2'd3;
`endif

// File: rtl/counter_preset.sv
// WIDTH-bit up counter with synchronous preset load; load has priority over count.
module counter_preset #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data_preset,
   input  logic             count_up,
   output logic [WIDTH-1:0] counter_out,
   output logic             carry_out
);
   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = data_preset;
      end else if (count_up) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Carry flags the cycle whose increment wraps the counter back to zero.
   assign carry_out   = count_up & (cnt_q == '1);
   assign counter_out = cnt_q;
endmodule

// File: rtl/counter_preset_ctrl.sv
// Sequencer running a programmable number of preset-to-all-ones count periods
// on one counter_preset, with tick per period and done at the end of the run.
module counter_preset_ctrl
   import counter_preset_ctrl_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int RWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic [WIDTH-1:0]  cfg_preset,
   input  logic [RWIDTH-1:0] cfg_repeat,
   output logic              busy,
   output logic              tick,
   output logic              done,
   output logic [RWIDTH-1:0] periods_left,
   output logic [WIDTH-1:0]  counter_out
);
   state_e            state_q, state_d;
   logic [WIDTH-1:0]  preset_q, preset_d;
   logic [RWIDTH-1:0] repeat_q, repeat_d;
   logic [RWIDTH-1:0] periods_left_q, periods_left_d;
   logic              tick_q, tick_d;
   logic              done_q, done_d;
   logic              load;
   logic              count_up;
   logic              carry_out;

   counter_preset #(.WIDTH(WIDTH)) u_counter_preset (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .data_preset (preset_q),
      .count_up    (count_up),
      .counter_out (counter_out),
      .carry_out   (carry_out)
   );

   always_comb begin
      state_d        = state_q;
      preset_d       = preset_q;
      repeat_d       = repeat_q;
      periods_left_d = periods_left_q;
      tick_d         = 1'b0;
      done_d         = 1'b0;
      load           = 1'b0;
      count_up       = 1'b0;
      // Stop freezes the counter, so no carry can fire in the abort cycle.
      if (stop) begin
         state_d        = S_IDLE;
         periods_left_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  preset_d       = cfg_preset;
                  repeat_d       = cfg_repeat;
                  periods_left_d = cfg_repeat;
                  state_d        = S_LOAD;
               end
            end
            S_LOAD: begin
               load    = 1'b1;
               state_d = S_COUNT;
            end
            S_COUNT: begin
               count_up = 1'b1;
               if (carry_out) begin
                  tick_d = 1'b1;
                  if (repeat_q == '0) begin
                     state_d = S_LOAD;
                  end else if (periods_left_q > RWIDTH'(1)) begin
                     periods_left_d = periods_left_q - RWIDTH'(1);
                     state_d        = S_LOAD;
                  end else begin
                     periods_left_d = '0;
                     done_d         = 1'b1;
                     state_d        = S_DONE;
                  end
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         preset_q       <= '0;
         repeat_q       <= '0;
         periods_left_q <= '0;
         tick_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         preset_q       <= preset_d;
         repeat_q       <= repeat_d;
         periods_left_q <= periods_left_d;
         tick_q         <= tick_d;
         done_q         <= done_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign tick         = tick_q;
   assign done         = done_q;
   assign periods_left = periods_left_q;
endmodule

// File: tb/tb_counter_preset_ctrl.sv
// Bench for counter_preset_ctrl: per-cycle expectations and tick/done events are
// queued at start and retired by a negedge monitor.
module tb_counter_preset_ctrl;
   import counter_preset_ctrl_pkg::*;

   localparam int W  = 4;
   localparam int RW = 4;

   typedef struct packed {
      int            cyc;
      logic          busy;
      logic [RW-1:0] pl;
      logic [W-1:0]  cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [W-1:0]  cfg_preset = '0;
   logic [RW-1:0] cfg_repeat = '0;
   logic          busy, tick, done;
   logic [RW-1:0] periods_left;
   logic [W-1:0]  counter_out;

   int   cyc = 0;
   int   run_n = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   int   exp_tick_q[$];
   int   exp_done_q[$];
   exp_t mon_x;
   int   mon_e;

   counter_preset_ctrl #(.WIDTH(W), .RWIDTH(RW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .stop         (stop),
      .cfg_preset   (cfg_preset),
      .cfg_repeat   (cfg_repeat),
      .busy         (busy),
      .tick         (tick),
      .done         (done),
      .periods_left (periods_left),
      .counter_out  (counter_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected outputs t cycles after the edge that accepted start (t=0 is LOAD).
   function automatic exp_t exp_at(input int p, input int r, input int t);
      exp_t x;
      int   period;
      int   o;
      period = (1 << W) - p + 1;
      x.cyc  = 0;
      if (r > 0 && t > r * period) begin
         x.busy = 1'b0;
         x.pl   = '0;
         x.cnt  = '0;
      end else begin
         o      = t % period;
         x.busy = 1'b1;
         x.cnt  = (o == 0) ? W'(0) : W'(p + o - 1);
         x.pl   = (r == 0) ? RW'(0) : RW'(r - t / period);
      end
      return x;
   endfunction

   // Called at a negedge; returns at the negedge of the LOAD cycle (t=0).
   task automatic start_run(input int p, input int r, input int t_last, input int stop_t);
      exp_t x;
      int   period;
      int   limit;
      period = (1 << W) - p + 1;
      limit  = (stop_t >= 0) ? stop_t : t_last;
      run_n  = cyc + 1;
      for (int t = 1; t <= t_last; t++) begin
         if (stop_t >= 0 && t > stop_t) begin
            x      = exp_at(p, r, stop_t);
            x.busy = 1'b0;
            x.pl   = '0;
         end else begin
            x = exp_at(p, r, t);
         end
         x.cyc = run_n + t;
         exp_q.push_back(x);
      end
      for (int k = 1; k * period <= limit && (r == 0 || k <= r); k++)
         exp_tick_q.push_back(run_n + k * period);
      if (r > 0 && r * period <= limit)
         exp_done_q.push_back(run_n + r * period);
      cfg_preset = W'(p);
      cfg_repeat = RW'(r);
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (tick) begin
            n_cmp++;
            if (exp_tick_q.size() == 0) begin
               n_err++;
               $display("FAIL tick_unexpected: tick=1 at cycle %0d, required 0", cyc);
            end else begin
               mon_e = exp_tick_q.pop_front();
               if (cyc != mon_e) begin
                  n_err++;
                  $display("FAIL tick_timing: tick at cycle %0d, required cycle %0d", cyc, mon_e);
               end
            end
         end
         if (done) begin
            n_cmp++;
            if (exp_done_q.size() == 0) begin
               n_err++;
               $display("FAIL done_unexpected: done=1 at cycle %0d, required 0", cyc);
            end else begin
               mon_e = exp_done_q.pop_front();
               if (cyc != mon_e) begin
                  n_err++;
                  $display("FAIL done_timing: done at cycle %0d, required cycle %0d", cyc, mon_e);
               end
            end
         end
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_x = exp_q.pop_front();
            n_cmp++;
            if ({busy, periods_left, counter_out} !== {mon_x.busy, mon_x.pl, mon_x.cnt}) begin
               n_err++;
               $display("FAIL cycle_outputs t=%0d: busy/periods_left/counter=%0b/%0d/%0d, required %0b/%0d/%0d",
                        cyc - run_n, busy, periods_left, counter_out, mon_x.busy, mon_x.pl, mon_x.cnt);
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp += 6;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b, required 0", busy); end
      if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %0b, required 0", tick); end
      if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b, required 0", done); end
      if (periods_left !== '0) begin n_err++; $display("FAIL reset_periods_left: got %0d, required 0", periods_left); end
      if (counter_out !== '0) begin n_err++; $display("FAIL reset_counter: got %0d, required 0", counter_out); end
      if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", dut.state_q, ST_IDLE); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_three_periods();
      start_run(12, 3, 17, -1);
      n_cmp += 2;
      if (dut.state_q !== ST_LOAD) begin n_err++; $display("FAIL three_load_state: got %0d, required %0d", dut.state_q, ST_LOAD); end
      if (periods_left !== RW'(3)) begin n_err++; $display("FAIL three_pl_at_load: got %0d, required 3", periods_left); end
      repeat (18) @(negedge clk);
      n_cmp++;
      if (exp_q.size() + exp_tick_q.size() + exp_done_q.size() != 0) begin
         n_err++; $display("FAIL three_events_missing: %0d left, required 0", exp_q.size() + exp_tick_q.size() + exp_done_q.size());
      end
   endtask

   task automatic test_short_period();
      start_run(15, 2, 6, -1);
      repeat (7) @(negedge clk);
      n_cmp++;
      if (exp_q.size() + exp_tick_q.size() + exp_done_q.size() != 0) begin
         n_err++; $display("FAIL short_events_missing: %0d left, required 0", exp_q.size() + exp_tick_q.size() + exp_done_q.size());
      end
   endtask

   task automatic test_continuous_stop();
      start_run(0, 0, 78, 75);
      repeat (75) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      n_cmp++;
      if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL cont_stop_state: got %0d, required %0d", dut.state_q, ST_IDLE); end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() + exp_tick_q.size() + exp_done_q.size() != 0) begin
         n_err++; $display("FAIL cont_events_missing: %0d left, required 0", exp_q.size() + exp_tick_q.size() + exp_done_q.size());
      end
   endtask

   task automatic test_stop_on_carry();
      start_run(10, 2, 16, 13);
      repeat (13) @(negedge clk);
      n_cmp++;
      if (counter_out !== W'(15)) begin n_err++; $display("FAIL carry_cycle_counter: got %0d, required 15", counter_out); end
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() + exp_tick_q.size() + exp_done_q.size() != 0) begin
         n_err++; $display("FAIL stopcarry_events_missing: %0d left, required 0", exp_q.size() + exp_tick_q.size() + exp_done_q.size());
      end
   endtask

   task automatic test_start_stop_same_cycle();
      cfg_preset = W'(3);
      cfg_repeat = RW'(1);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      n_cmp += 2;
      if (busy !== 1'b0) begin n_err++; $display("FAIL startstop_busy: got %0b, required 0", busy); end
      if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL startstop_state: got %0d, required %0d", dut.state_q, ST_IDLE); end
      repeat (3) @(negedge clk);
      n_cmp += 2;
      if (busy !== 1'b0) begin n_err++; $display("FAIL startstop_busy_later: got %0b, required 0", busy); end
      if (counter_out !== W'(15)) begin n_err++; $display("FAIL startstop_counter: got %0d, required 15", counter_out); end
   endtask

   task automatic test_start_while_busy();
      start_run(12, 2, 12, -1);
      repeat (3) @(negedge clk);
      cfg_preset = W'(5);
      cfg_repeat = RW'(7);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      n_cmp++;
      if (exp_q.size() + exp_tick_q.size() + exp_done_q.size() != 0) begin
         n_err++; $display("FAIL busystart_events_missing: %0d left, required 0", exp_q.size() + exp_tick_q.size() + exp_done_q.size());
      end
   endtask

   task automatic test_async_reset();
      start_run(8, 0, 5, -1);
      repeat (6) @(negedge clk);
      n_cmp++;
      if (dut.state_q !== ST_COUNT) begin n_err++; $display("FAIL arst_pre_state: got %0d, required %0d", dut.state_q, ST_COUNT); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp += 6;
      if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %0b, required 0", busy); end
      if (tick !== 1'b0) begin n_err++; $display("FAIL arst_tick: got %0b, required 0", tick); end
      if (done !== 1'b0) begin n_err++; $display("FAIL arst_done: got %0b, required 0", done); end
      if (periods_left !== '0) begin n_err++; $display("FAIL arst_periods_left: got %0d, required 0", periods_left); end
      if (counter_out !== '0) begin n_err++; $display("FAIL arst_counter: got %0d, required 0", counter_out); end
      if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL arst_state: got %0d, required %0d", dut.state_q, ST_IDLE); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp += 2;
      if (busy !== 1'b0) begin n_err++; $display("FAIL arst_after_busy: got %0b, required 0", busy); end
      if (exp_q.size() + exp_tick_q.size() + exp_done_q.size() != 0) begin
         n_err++; $display("FAIL arst_events_missing: %0d left, required 0", exp_q.size() + exp_tick_q.size() + exp_done_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_three_periods();
      test_short_period();
      test_continuous_stop();
      test_stop_on_carry();
      test_start_stop_same_cycle();
      test_start_while_busy();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
